// File: rtl/nn_ctrl_pkg.sv
// Shared types and Q8.8 constants for the inference run controller.
package nn_ctrl_pkg;

  localparam int DATA_WIDTH      = 16;
  localparam int DATA_FRAC_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NN_RESET,
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } nn_ctrl_state_t;

endpackage

// File: rtl/result_stabilizer.sv
// Debounces latched predictions: stable_index follows a class only
// after STABLE_COUNT consecutive confident hits on it.
module result_stabilizer #(
  parameter int INDEX_WIDTH  = 4,
  parameter int STABLE_COUNT = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   latch,
  input  logic                   confident,
  input  logic [INDEX_WIDTH-1:0] index,
  output logic [INDEX_WIDTH-1:0] stable_index
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_COUNT);

  logic [INDEX_WIDTH-1:0] cand;
  logic [INDEX_WIDTH-1:0] next_cand;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          next_cnt;

  always_comb begin
    next_cand = cand;
    next_cnt  = cnt;
    if (!confident) begin
      next_cnt = '0;
    end else if (index == cand) begin
      if (cnt != CMAX) next_cnt = cnt + 1'b1;
    end else begin
      next_cand = index;
      next_cnt  = CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand         <= '0;
      cnt          <= '0;
      stable_index <= '0;
    end else if (latch) begin
      cand <= next_cand;
      cnt  <= next_cnt;
      if (next_cnt == CMAX) stable_index <= next_cand;
    end
  end

endmodule

// File: rtl/nn_run_controller.sv
// Sequences reset/settle/run of the network core, latches the argmax
// result, guards each run with a watchdog and debounces the display.
module nn_run_controller
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_OUTPUTS    = 10,
  parameter int INDEX_WIDTH    = $clog2(NUM_OUTPUTS),
  parameter int VALUE_WIDTH    = DATA_WIDTH,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STABLE_COUNT   = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mode,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] threshold,
  input  logic                   max_valid,
  input  logic [INDEX_WIDTH-1:0] max_index,
  input  logic [VALUE_WIDTH-1:0] max_value,
  output logic                   nn_reset,
  output logic                   nn_valid,
  output logic                   busy,
  output logic                   result_valid,
  output logic [INDEX_WIDTH-1:0] result_index,
  output logic [VALUE_WIDTH-1:0] result_value,
  output logic                   result_confident,
  output logic [INDEX_WIDTH-1:0] stable_index,
  output logic                   timeout_err,
  output logic [15:0]            run_count
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST =
    WW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  nn_ctrl_state_t state;
  logic [SW-1:0]  settle_cnt;
  logic [WW-1:0]  wd_cnt;
  logic           wd_fire;

  assign wd_fire  = WD_EN && (wd_cnt == WD_LAST);
  assign nn_reset = (state == ST_NN_RESET);
  assign nn_valid = (state == ST_RUN);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      settle_cnt       <= '0;
      wd_cnt           <= '0;
      result_valid     <= 1'b0;
      result_index     <= '0;
      result_value     <= '0;
      result_confident <= 1'b0;
      timeout_err      <= 1'b0;
      run_count        <= '0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (mode || start) state <= ST_NN_RESET;
        end
        ST_NN_RESET: begin
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            wd_cnt <= '0;
            state  <= ST_RUN;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // a result on the watchdog's last cycle still counts
          if (max_valid) begin
            result_valid     <= 1'b1;
            result_index     <= max_index;
            result_value     <= max_value;
            result_confident <=
              $signed(max_value) >= $signed(threshold);
            run_count        <= run_count + 16'd1;
            state            <= ST_DONE;
          end else if (wd_fire) begin
            timeout_err <= 1'b1;
            state       <= ST_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  result_stabilizer #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .STABLE_COUNT(STABLE_COUNT)
  ) u_stab (
    .clk         (clk),
    .reset_n     (reset_n),
    .latch       (result_valid),
    .confident   (result_confident),
    .index       (result_index),
    .stable_index(stable_index)
  );

endmodule

// File: tb/tb_nn_run_controller.sv
// Randomised scenario bench for nn_run_controller with a history-based model.
module tb_nn_run_controller;

  localparam int NO = 10;
  localparam int IW = 4;
  localparam int VW = 16;
  localparam int SC = 3;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mode;
  logic          start;
  logic [VW-1:0] threshold;
  logic          max_valid;
  logic [IW-1:0] max_index;
  logic [VW-1:0] max_value;
  logic          nn_reset;
  logic          nn_valid;
  logic          busy;
  logic          result_valid;
  logic [IW-1:0] result_index;
  logic [VW-1:0] result_value;
  logic          result_confident;
  logic [IW-1:0] stable_index;
  logic          timeout_err;
  logic [15:0]   run_count;

  always #5 clk = ~clk;

  nn_run_controller #(
    .NUM_OUTPUTS   (NO),
    .INDEX_WIDTH   (IW),
    .VALUE_WIDTH   (VW),
    .SETTLE_CYCLES (1),
    .TIMEOUT_CYCLES(TO),
    .STABLE_COUNT  (SC)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mode            (mode),
    .start           (start),
    .threshold       (threshold),
    .max_valid       (max_valid),
    .max_index       (max_index),
    .max_value       (max_value),
    .nn_reset        (nn_reset),
    .nn_valid        (nn_valid),
    .busy            (busy),
    .result_valid    (result_valid),
    .result_index    (result_index),
    .result_value    (result_value),
    .result_confident(result_confident),
    .stable_index    (stable_index),
    .timeout_err     (timeout_err),
    .run_count       (run_count)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0]   m_runs;
  logic [IW-1:0] m_stable;
  logic [IW-1:0] m_idx;
  logic [VW-1:0] m_val;
  logic          m_conf;
  logic          m_tout;
  logic [IW:0]   hist[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_runs = 0; m_stable = 0; m_idx = 0; m_val = 0;
    m_conf = 0; m_tout = 0;
    hist.delete();
  endtask

  // display class = last class seen SC times in a row, all confident
  function automatic logic [IW-1:0] model_stable(input logic [IW-1:0] cur);
    int n;
    n = hist.size();
    if (n < SC) return cur;
    for (int k = n - SC; k < n; k++)
      if (!hist[k][IW] || hist[k][IW-1:0] != hist[n-1][IW-1:0]) return cur;
    return hist[n-1][IW-1:0];
  endfunction

  task automatic do_run(input bit cont, input int delay,
                        input logic [IW-1:0] idx,
                        input logic [VW-1:0] val, input bit glitch);
    bit lat;
    logic signed [VW-1:0] sv, st;
    lat = (delay < TO);
    mode = cont;
    if (!cont) start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (nn_reset !== 1'b1 || nn_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nn_reset_phase got rst=%b vld=%b busy=%b exp 1 0 1",
               nn_reset, nn_valid, busy);
    end
    if (glitch) begin max_valid = 1'b1; max_index = idx ^ 4'd1; end
    tick;
    checks++;
    if (nn_reset !== 1'b0 || nn_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL settle_phase got rst=%b vld=%b busy=%b exp 0 0 1",
               nn_reset, nn_valid, busy);
    end
    tick;
    max_valid = 1'b0;
    for (int c = 0; c < TO; c++) begin
      checks++;
      if (nn_valid !== 1'b1 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL run_cycle%0d got vld=%b rv=%b exp 1 0",
                 c, nn_valid, result_valid);
      end
      if (c == delay) begin
        max_valid = 1'b1; max_index = idx; max_value = val;
      end else if (glitch) begin
        start = 1'b1;
      end
      tick;
      start = 1'b0;
      if (c == delay) break;
    end
    max_valid = 1'b0;
    if (lat) begin
      sv = val; st = threshold;
      m_idx = idx; m_val = val; m_conf = (sv >= st);
      m_runs = m_runs + 16'd1;
      hist.push_back({m_conf, idx});
    end else begin
      m_tout = 1'b1;
    end
    checks++;
    if (result_valid !== lat) begin
      errors++;
      $display("FAIL done_result_valid got %b exp %b", result_valid, lat);
    end
    checks++;
    if (result_index !== m_idx || result_value !== m_val ||
        result_confident !== m_conf) begin
      errors++;
      $display("FAIL done_result got %0d/%h/%b exp %0d/%h/%b",
               result_index, result_value, result_confident,
               m_idx, m_val, m_conf);
    end
    checks++;
    if (run_count !== m_runs || timeout_err !== m_tout) begin
      errors++;
      $display("FAIL done_counters got runs=%0d to=%b exp runs=%0d to=%b",
               run_count, timeout_err, m_runs, m_tout);
    end
    checks++;
    if (nn_valid !== 1'b0 || busy !== 1'b1 || stable_index !== m_stable) begin
      errors++;
      $display("FAIL done_state got vld=%b busy=%b stab=%0d exp 0 1 %0d",
               nn_valid, busy, stable_index, m_stable);
    end
    if (lat) m_stable = model_stable(m_stable);
    tick;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || stable_index !== m_stable) begin
      errors++;
      $display("FAIL idle_after_run got busy=%b rv=%b stab=%0d exp 0 0 %0d",
               busy, result_valid, stable_index, m_stable);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; mode = 1'b0; start = 1'b0; max_valid = 1'b1;
    max_index = 4'd7; max_value = 16'h1234; threshold = 16'h0;
    tick; tick;
    reset_n = 1'b1; max_valid = 1'b0;
    model_reset();
    checks++;
    if ({nn_reset, nn_valid, busy, result_valid, result_confident,
         timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b%b%b%b exp 000000", nn_reset,
               nn_valid, busy, result_valid, result_confident, timeout_err);
    end
    checks++;
    if (result_index !== 0 || result_value !== 0 || stable_index !== 0 ||
        run_count !== 0) begin
      errors++;
      $display("FAIL reset_regs got %0d/%h/%0d/%0d exp zeros",
               result_index, result_value, stable_index, run_count);
    end
    repeat (3) tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_single_shot;
    threshold = 16'h0100;
    do_run(1'b0, 7, 4'd7, 16'h0300, 1'b0);
  endtask

  task automatic test_stabilizer;
    logic [IW-1:0] seq[5];
    seq = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd3};
    threshold = 16'h0100;
    foreach (seq[i]) do_run(1'b1, i, seq[i], 16'h0300, 1'b0);
    mode = 1'b0;
    checks++;
    if (stable_index !== 4'd3) begin
      errors++;
      $display("FAIL stab_seq got %0d exp 3", stable_index);
    end
  endtask

  task automatic test_below_threshold;
    threshold = 16'h0000;
    do_run(1'b0, 2, 4'd5, 16'hFF00, 1'b0);
    do_run(1'b0, 1, 4'd5, 16'h0080, 1'b0);
    do_run(1'b0, 3, 4'd5, 16'h0000, 1'b0);
    checks++;
    if (stable_index !== 4'd3) begin
      errors++;
      $display("FAIL stab_after_low got %0d exp 3", stable_index);
    end
    do_run(1'b0, 0, 4'd5, 16'h7FFF, 1'b0);
  endtask

  task automatic test_watchdog;
    threshold = 16'h0100;
    do_run(1'b0, TO, 4'd2, 16'h0400, 1'b0);
    do_run(1'b0, TO - 1, 4'd2, 16'h0400, 1'b0);
    do_run(1'b0, TO + 1, 4'd6, 16'h0400, 1'b0);
  endtask

  task automatic test_glitch;
    threshold = 16'hFF00;
    do_run(1'b0, 4, 4'd8, 16'hFF80, 1'b1);
    do_run(1'b1, 0, 4'd8, 16'h0001, 1'b1);
    mode = 1'b0;
  endtask

  task automatic test_random;
    logic [IW-1:0] pick[3];
    logic [VW-1:0] thr[3];
    pick = '{4'd2, 4'd6, 4'd9};
    thr = '{16'h0000, 16'h0100, 16'hFF00};
    for (int r = 0; r < 30; r++) begin
      threshold = thr[$urandom_range(0, 2)];
      do_run(1'($urandom_range(0, 1)), $urandom_range(0, TO + 1),
             pick[$urandom_range(0, 2)], 16'($urandom),
             1'($urandom_range(0, 1)));
    end
    mode = 1'b0;
  endtask

  task automatic test_reset_midrun;
    mode = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    model_reset();
    checks++;
    if ({nn_reset, nn_valid, busy, result_valid, result_confident,
         timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL midrun_flags got %b%b%b%b%b%b exp 000000", nn_reset,
               nn_valid, busy, result_valid, result_confident, timeout_err);
    end
    checks++;
    if (result_index !== 0 || result_value !== 0 || stable_index !== 0 ||
        run_count !== 0) begin
      errors++;
      $display("FAIL midrun_regs got %0d/%h/%0d/%0d exp zeros",
               result_index, result_value, stable_index, run_count);
    end
    threshold = 16'h0100;
    do_run(1'b0, 2, 4'd5, 16'h0200, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_stabilizer();
    test_below_threshold();
    test_watchdog();
    test_glitch();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_run_controller.md
# nn_run_controller

Parametrised inference sequencer sitting between the input shift register / board I/O and the `NeuralNetwork` core. Owns the reset → settle → start → wait-for-argmax cycle and supports single-shot and continuous run modes. Adds a watchdog timeout, a confidence threshold on the winning score, and a stabilised display result that changes only after N consecutive identical confident predictions. Feeds the 7-segment driver and LEDs at board top level.

## Interface
- `NUM_OUTPUTS`, 10: number of network output classes.
- `INDEX_WIDTH`, `$clog2(NUM_OUTPUTS)`: width of class index.
- `VALUE_WIDTH`, 16: width of the signed Q8.8 max score.
- `SETTLE_CYCLES`, 1: idle cycles between `nn_reset` and `nn_valid` (≥1).
- `TIMEOUT_CYCLES`, 4096: RUN cycles before watchdog fires; 0 disables the watchdog.
- `STABLE_COUNT`, 3: consecutive matching confident results needed to update `stable_index` (≥1).
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `mode`  in  1  0 = single-shot, 1 = continuous.
- `start`  in  1  single-shot trigger; sampled only in IDLE.
- `threshold`  in  VALUE_WIDTH  signed minimum score for a confident result.
- `max_valid`  in  1  argmax done, from the network.
- `max_index`  in  INDEX_WIDTH  winning class.
- `max_value`  in  VALUE_WIDTH  winning score, signed.
- `nn_reset`  out  1  network reset, active high.
- `nn_valid`  out  1  network start/hold.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  one-cycle pulse when a new result is latched.
- `result_index`  out  INDEX_WIDTH  last latched class.
- `result_value`  out  VALUE_WIDTH  last latched score.
- `result_confident`  out  1  `result_value >= threshold`, signed, evaluated at latch.
- `stable_index`  out  INDEX_WIDTH  debounced class for display.
- `timeout_err`  out  1  sticky watchdog flag.
- `run_count`  out  16  completed runs, wraps at 2^16.

## Operation
- States: IDLE, NN_RESET, SETTLE, RUN, DONE.
- IDLE → NN_RESET when `mode`=1, or when `mode`=0 and `start`=1; otherwise hold.
- NN_RESET: 1 cycle; `nn_reset`=1. → SETTLE.
- SETTLE: exactly `SETTLE_CYCLES` cycles. → RUN.
- RUN: `nn_valid`=1 every cycle. On `max_valid`=1: latch index/value/confidence, → DONE. If the watchdog expires first: set `timeout_err`, no latch, → DONE.
- DONE: 1 cycle. → IDLE.
- `nn_reset`, `nn_valid`, `busy` decode from the state register only (Moore); no combinational path from inputs.
- Stabiliser runs on each latch:
  - Confident result with index equal to the candidate: increment the saturating match counter.
  - Confident result with a different index: candidate ← index, counter ← 1.
  - Non-confident result: counter ← 0.
  - When the counter reaches `STABLE_COUNT`: `stable_index` ← candidate.
- `run_count` increments on each latch. Timeouts do not count.
- `timeout_err` clears only on reset.
- Reset values: state IDLE. All outputs 0, counters 0, candidate 0.

## Timing
- `start` high in IDLE at cycle t: `nn_reset` high at t+1; `nn_valid` high from t+2+SETTLE_CYCLES.
- `max_valid` high in RUN at cycle m:
  - `nn_valid` drops at m+1.
  - `result_*` registered and `result_valid` pulsed at m+1.
  - `stable_index` updates at m+2 if the threshold count is met.
  - IDLE at m+2.
- Continuous mode: NN_RESET again at m+3.
- Watchdog counts RUN cycles from 0 and fires on the cycle the count equals `TIMEOUT_CYCLES`-1 without `max_valid`. `max_valid` on that same cycle wins; no error is flagged.
- `max_valid` outside RUN is ignored.
- `start` outside IDLE is ignored; it is not queued.
- A `mode` change takes effect at the next IDLE evaluation.
- `reset_n` low in any cycle: all state is at reset values on the next edge, mid-run included.

## Structure
- Package `nn_ctrl_pkg`: `nn_ctrl_state_t` enum, Q8.8 format constants (`DATA_WIDTH`=16, `DATA_FRAC_WIDTH`=8).
- Sub-module `result_stabilizer`: candidate register, saturating match counter, `stable_index` register. Parameters: `INDEX_WIDTH`, `STABLE_COUNT`.
- The top controller holds the FSM, watchdog, result latch and `run_count`.

## Test plan
- Single-shot, SETTLE_CYCLES=1: `start` at cycle 10, `max_valid` at 20 with index 7, value 0x0300, threshold 0x0100 → `nn_reset` at 11, `nn_valid` 13..20, `result_valid` pulse at 21, `result_index`=7, `result_confident`=1, `run_count`=1.
- Continuous mode, STABLE_COUNT=3: confident indices 4,4,3,3,3 → `stable_index` stays 0 through the fourth run, becomes 3 one cycle after the fifth latch.
- Below threshold: value 0xFF00 (−1.0), threshold 0 → `result_confident`=0, stabiliser counter reset, `stable_index` unchanged.
- Watchdog, TIMEOUT_CYCLES=8, no `max_valid` → `timeout_err`=1 after 8 RUN cycles, `result_valid` never pulses, `run_count` unchanged. `max_valid` on the 8th cycle → no error.
- `reset_n` low in RUN → next cycle all outputs 0, state IDLE. `start` and `max_valid` pulses during a run → ignored, exactly one result per run.
